// File: rtl/fft2d_tile_scheduler.sv
// Purpose: issues tile reads, engine 'next' strobes and write-backs for a run of 4x4 FFT tiles.
// Latency: first read the cycle after start, fft_next one cycle after each read, write combinational on next_out.
// Backpressure: reads stall while MAX_INFLIGHT tiles are outstanding; a write frees a slot in the same cycle.
module fft2d_tile_scheduler #(
  parameter int ADDR_WIDTH   = 13,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_rd_addr,
  input  logic [ADDR_WIDTH-1:0] i_base_wr_addr,
  input  logic [ADDR_WIDTH-1:0] i_num_tiles,
  output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
  output logic                  o_mem_rd_issue,
  output logic                  o_fft_next,
  input  logic                  i_fft_next_out,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overrun
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] LP_MAX = IW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base_rd;
  logic [ADDR_WIDTH-1:0] r_base_wr;
  logic [ADDR_WIDTH-1:0] r_num;
  logic [ADDR_WIDTH-1:0] r_issued;
  logic [ADDR_WIDTH-1:0] r_written;
  logic [IW-1:0]         r_inflight;
  logic                  r_fft_next;
  logic                  r_overrun;

  logic                  w_start_acc;
  logic                  w_wr_acc;
  logic                  w_ovr_evt;
  logic                  w_rd_issue;
  logic [ADDR_WIDTH-1:0] w_issued_nxt;
  logic [ADDR_WIDTH-1:0] w_written_nxt;

  // Issue/accept qualifiers; a write in the same cycle lets a stalled read go immediately.
  always_comb begin
    w_start_acc   = (r_state == S_IDLE) && i_start;
    w_wr_acc      = i_fft_next_out && (r_inflight != '0);
    w_ovr_evt     = i_fft_next_out && (r_inflight == '0);
    w_rd_issue    = (r_state == S_RUN) && (r_issued < r_num) &&
                    ((r_inflight < LP_MAX) || w_wr_acc);
    w_issued_nxt  = r_issued + ADDR_WIDTH'(w_rd_issue);
    w_written_nxt = r_written + ADDR_WIDTH'(w_wr_acc);
  end

  // Next-state decode; completion looks at post-update counts so done follows the last write directly.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_num_tiles == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_issued_nxt == r_num) begin
          w_state_nxt = (w_written_nxt == r_num) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_written_nxt == r_num) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Job parameters, progress counters, engine strobe and sticky overrun flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_base_rd  <= '0;
      r_base_wr  <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_written  <= '0;
      r_inflight <= '0;
      r_fft_next <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_fft_next <= w_rd_issue;
      if (w_start_acc) begin
        r_base_rd  <= i_base_rd_addr;
        r_base_wr  <= i_base_wr_addr;
        r_num      <= i_num_tiles;
        r_issued   <= '0;
        r_written  <= '0;
        r_inflight <= '0;
        // A stray engine output coinciding with start still counts as an overrun.
        r_overrun  <= w_ovr_evt;
      end else begin
        r_issued  <= w_issued_nxt;
        r_written <= w_written_nxt;
        r_overrun <= r_overrun | w_ovr_evt;
        case ({w_rd_issue, w_wr_acc})
          2'b10:   r_inflight <= r_inflight + IW'(1);
          2'b01:   r_inflight <= r_inflight - IW'(1);
          default: r_inflight <= r_inflight;
        endcase
      end
    end
  end

  assign o_mem_rd_addr  = r_base_rd + r_issued;
  assign o_mem_rd_issue = w_rd_issue;
  assign o_fft_next     = r_fft_next;
  assign o_mem_we       = w_wr_acc;
  assign o_mem_wr_addr  = r_base_wr + r_written;
  assign o_busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done         = (r_state == S_DONE);
  assign o_overrun      = r_overrun;

endmodule

// File: doc/fft2d_tile_scheduler.md
# fft2d_tile_scheduler

Sequences the 4x4 2-D FFT engine over a contiguous run of image tiles held in the image block memory. Once started, it issues tile read addresses, pulses the engine's `next` one cycle later when read data is valid, and writes each transformed tile back to a destination region when the engine raises `next_out`. Up to `MAX_INFLIGHT` tiles overlap inside the engine. The block owns only control and addresses; tile data is wired directly between memory and engine at the top level.

## Interface
- `ADDR_WIDTH`, 13: tile address width, matching image memory depth.
- `MAX_INFLIGHT`, 4: max tiles read but not yet written back (1..15).
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk`).
- `start`  in  1  one-cycle request to begin a job; ignored unless idle.
- `base_rd_addr`  in  ADDR_WIDTH  first source tile address, latched on accepted `start`.
- `base_wr_addr`  in  ADDR_WIDTH  first destination tile address, latched on accepted `start`.
- `num_tiles`  in  ADDR_WIDTH  tile count, latched on accepted `start`; 0 is legal.
- `mem_rd_addr`  out  ADDR_WIDTH  image memory read address.
- `mem_rd_issue`  out  1  high in cycles where `mem_rd_addr` is a real tile read.
- `fft_next`  out  1  one-cycle pulse to the engine: input tile valid this cycle.
- `fft_next_out`  in  1  engine output tile valid this cycle.
- `mem_we`  out  1  image memory write enable.
- `mem_wr_addr`  out  ADDR_WIDTH  image memory write address.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the last tile is written.
- `overrun`  out  1  sticky: `fft_next_out` arrived with no tile outstanding; cleared on accepted `start`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DRAIN when the issued count reaches `num_tiles`.
  - DRAIN -> DONE when the written count reaches `num_tiles`.
  - DONE -> IDLE unconditionally after one cycle.
- Job of size 0: IDLE -> DONE directly; no read, `next` or write is issued.
- Counters, all ADDR_WIDTH wide, cleared on accepted `start`:
  - `issued`, `written`.
  - `inflight`, width ceil(log2(MAX_INFLIGHT+1)).
- Read issue: in RUN, a read issues when `issued < num_tiles` and `inflight < MAX_INFLIGHT`.
  - `mem_rd_issue` = 1 and `mem_rd_addr = base_rd_addr + issued`, mod 2^ADDR_WIDTH (wraps silently).
  - `issued` increments.
- `fft_next` is the registered copy of `mem_rd_issue`, one cycle later, to cover the 1-cycle registered memory read latency.
- Write: when `fft_next_out` = 1 and `inflight > 0`, combinationally:
  - `mem_we` = 1 and `mem_wr_addr = base_wr_addr + written` (wraps).
  - `written` increments.
- `inflight` increments on read issue and decrements on an accepted write. On the same cycle, it is unchanged.
- `fft_next_out` with `inflight` = 0 (including in IDLE or DONE): `mem_we` stays 0, counters unchanged, `overrun` is set.
- `start` while not IDLE is ignored. Latched parameters do not change mid-job.
- When idle, `mem_rd_addr` and `mem_wr_addr` hold their last values. Their value matters only when qualified by `mem_rd_issue` or `mem_we`.

## Timing
- Reset (`reset` = 0 at a clock edge):
  - State -> IDLE; all counters, `busy`, `done`, `overrun`, `fft_next`, `mem_rd_issue` -> 0.
  - `mem_rd_addr` and `mem_wr_addr` -> 0.
  - Reset mid-job abandons the job. Engine outputs arriving later are treated as overrun.
- `start` sampled in cycle 0. In cycle 1: `busy` = 1, first `mem_rd_issue`. In cycle 2: first `fft_next`.
- Peak throughput is 1 tile/cycle while `inflight < MAX_INFLIGHT`. Issue stalls when the limit is reached and resumes in the same cycle a write frees a slot.
- `done` is asserted the cycle after the final write. `busy` falls in the same cycle `done` rises.
- A new `start` is accepted in the cycle after `done`.
- For `num_tiles` = 0: `done` in cycle 1 and `busy` never rises.

## Test plan
- Reset, then `num_tiles`=3, `base_rd`=0x010, `base_wr`=0x100, engine latency 5:
  - reads at 0x010..0x012 in cycles 1..3; `fft_next` in cycles 2..4.
  - writes to 0x100..0x102 in cycles 7..9; `done` in cycle 10.
- `MAX_INFLIGHT`=4, `num_tiles`=10, engine latency 20: exactly 4 reads issue, then stall. Each `next_out` releases one read in the same cycle; 10 writes, then `done`.
- `num_tiles`=0: `done` in cycle 1; `mem_rd_issue`, `fft_next`, `mem_we` never assert; `busy` stays 0.
- `base_rd`=0x1FFE, `base_wr`=0x1FFF, `num_tiles`=3: read addresses 0x1FFE, 0x1FFF, 0x0000; write addresses 0x1FFF, 0x0000, 0x0001.
- `fft_next_out` pulsed while idle: no `mem_we`, `overrun`=1. The next `start` clears `overrun`, and that job completes normally.
- `reset`=0 asserted in the middle of a 6-tile job, then engine `next_out` pulses arrive: all outputs 0 after reset and no writes occur. A subsequent job runs from clean counters.
